// File: rtl/ecc_mont_result_collector.sv
// Result collector for the Montgomery PE array: buffers the word-serial product,
// applies the final conditional subtraction of p and streams the reduced result out.
module ecc_mont_result_collector #(
    parameter int unsigned RADIX = 32,
    parameter int unsigned WORDS = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RADIX-1:0]         res_word_in,
    input  logic                     res_carry_in,
    output logic [$clog2(WORDS)-1:0] p_addr,
    input  logic [RADIX-1:0]         p_word_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RADIX-1:0]         out_word,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned      IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SUB, OUTPUT} state_t;

    state_t           r_state;
    logic [RADIX-1:0] r_raw  [WORDS];
    logic [RADIX-1:0] r_diff [WORDS];
    logic [IDX_W-1:0] r_idx;
    logic             r_borrow;
    logic             r_carry_hi;
    logic             r_sel_d;
    logic             r_sub_done;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;
    logic [RADIX-1:0] r_out_word;

    logic [RADIX:0]   w_sub;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_sel_fin;
    logic [RADIX-1:0] w_first_word;
    logic [RADIX-1:0] w_next_word;

    assign w_sub        = {1'b0, r_raw[r_idx]} - {1'b0, p_word_in} - {{RADIX{1'b0}}, r_borrow};
    assign w_idx_nxt    = r_idx + IDX_W'(1);
    // Keep d when the top carry is set or no final borrow (covers equality -> 0).
    assign w_sel_fin    = r_carry_hi | ~r_borrow;
    assign w_first_word = w_sel_fin ? r_diff[0] : r_raw[0];
    assign w_next_word  = r_sel_d ? r_diff[w_idx_nxt] : r_raw[w_idx_nxt];

    assign in_ready  = (r_state == COLLECT);
    assign busy      = (r_state != IDLE);
    assign p_addr    = r_idx;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_last  = r_out_last;
    assign done      = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_borrow    <= 1'b0;
            r_carry_hi  <= 1'b0;
            r_sel_d     <= 1'b0;
            r_sub_done  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_word  <= '0;
            r_done      <= 1'b0;
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_raw[i]  <= '0;
                r_diff[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (start_in) begin
                r_state     <= COLLECT;
                r_idx       <= '0;
                r_borrow    <= 1'b0;
                r_carry_hi  <= 1'b0;
                r_sel_d     <= 1'b0;
                r_sub_done  <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_word  <= '0;
            end else begin
                case (r_state)
                    IDLE: ;
                    COLLECT: begin
                        if (in_valid) begin
                            r_raw[r_idx] <= res_word_in;
                            if (r_idx == LAST_IDX) begin
                                r_carry_hi <= res_carry_in;
                                r_idx      <= '0;
                                r_borrow   <= 1'b0;
                                r_sub_done <= 1'b0;
                                r_state    <= SUB;
                            end else begin
                                r_idx <= w_idx_nxt;
                            end
                        end
                    end
                    SUB: begin
                        // Extra cycle after the last word registers the select and the first output word.
                        if (!r_sub_done) begin
                            r_diff[r_idx] <= w_sub[RADIX-1:0];
                            r_borrow      <= w_sub[RADIX];
                            if (r_idx == LAST_IDX) begin
                                r_sub_done <= 1'b1;
                                r_idx      <= '0;
                            end else begin
                                r_idx <= w_idx_nxt;
                            end
                        end else begin
                            r_sel_d     <= w_sel_fin;
                            r_out_word  <= w_first_word;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (LAST_IDX == '0);
                            r_state     <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            if (r_out_last) begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_out_word  <= '0;
                                r_idx       <= '0;
                                r_done      <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_idx      <= w_idx_nxt;
                                r_out_word <= w_next_word;
                                r_out_last <= (w_idx_nxt == LAST_IDX);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ecc_mont_result_collector.sv
// Self-checking bench for ecc_mont_result_collector (RADIX=8, WORDS=2, p=0xF1):
// vector table, randomized values against an arithmetic model, abort and reset sequences.
module tb_ecc_mont_result_collector;

    localparam int unsigned RADIX = 8;
    localparam int unsigned WORDS = 2;
    localparam logic [15:0] P     = 16'h00F1;

    logic             clk;
    logic             reset_n;
    logic             start_in;
    logic             in_valid;
    logic             in_ready;
    logic [RADIX-1:0] res_word_in;
    logic             res_carry_in;
    logic [0:0]       p_addr;
    logic [RADIX-1:0] p_word_in;
    logic             out_valid;
    logic             out_ready;
    logic [RADIX-1:0] out_word;
    logic             out_last;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    ecc_mont_result_collector #(
        .RADIX(RADIX),
        .WORDS(WORDS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start_in(start_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .res_word_in(res_word_in),
        .res_carry_in(res_carry_in),
        .p_addr(p_addr),
        .p_word_in(p_word_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always_comb p_word_in = (p_addr == 1'b1) ? P[15:8] : P[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic        c;
        logic [15:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [15:0] ref_model(input logic [16:0] v);
        logic [16:0] pp;
        pp = {1'b0, P};
        if (v >= pp) return 16'(v - pp);
        return v[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic c);
        in_valid     = 1'b1;
        res_word_in  = w;
        res_carry_in = c;
        @(negedge clk);
        check("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid     = 1'b0;
        res_carry_in = 1'b0;
    endtask

    task automatic collect(input string name, input logic [15:0] exp, input int stall);
        int lat;
        logic [15:0] e;
        e = exp;
        out_ready = (stall == 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, WORDS + 1);
        if (!out_valid) begin
            out_ready = 1'b1;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({name, " stall valid"}, out_valid, 1);
            check({name, " stall word"}, out_word, e[7:0]);
            check({name, " stall last"}, out_last, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < int'(WORDS); k++) begin
            @(negedge clk);
            check({name, " valid"}, out_valid, 1);
            check({name, " word"}, out_word, e[k*8 +: 8]);
            check({name, " last"}, out_last, (k == int'(WORDS) - 1) ? 1 : 0);
            check({name, " done early"}, done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({name, " done"}, done, 1);
        check({name, " valid drop"}, out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " done width"}, done, 0);
        check({name, " idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string name, input logic [7:0] w0, input logic [7:0] w1,
                           input logic c, input logic [15:0] exp, input int stall);
        start_pulse();
        send_word(w0, 1'b0);
        send_word(w1, c);
        collect(name, exp, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [16:0] v;
        logic [15:0] e;
        int          st;
        int          seen_valid;

        vecs[0] = '{w0: 8'h05, w1: 8'h01, c: 1'b0, exp: 16'h0014, stall: 0};
        vecs[1] = '{w0: 8'h10, w1: 8'h00, c: 1'b0, exp: 16'h0010, stall: 0};
        vecs[2] = '{w0: 8'hF1, w1: 8'h00, c: 1'b0, exp: 16'h0000, stall: 0};
        vecs[3] = '{w0: 8'h00, w1: 8'h00, c: 1'b1, exp: 16'hFF0F, stall: 0};
        vecs[4] = '{w0: 8'h05, w1: 8'h01, c: 1'b0, exp: 16'h0014, stall: 3};
        vecs[5] = '{w0: 8'hF0, w1: 8'h00, c: 1'b0, exp: 16'h00F0, stall: 0};
        vecs[6] = '{w0: 8'hE1, w1: 8'h01, c: 1'b0, exp: 16'h00F0, stall: 1};

        reset_n      = 1'b0;
        start_in     = 1'b0;
        in_valid     = 1'b0;
        res_word_in  = '0;
        res_carry_in = 1'b0;
        out_ready    = 1'b1;
        #2;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_word", out_word, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst p_addr", p_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Words offered while idle must not be captured.
        in_valid    = 1'b1;
        res_word_in = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].c, vecs[i].exp, vecs[i].stall);

        for (int i = 0; i < 24; i++) begin
            v  = 17'($urandom_range(0, 2 * 32'h00F1 - 1));
            st = int'($urandom_range(0, 2));
            e  = ref_model(v);
            run_vec($sformatf("rnd%0d", i), v[7:0], v[15:8], v[16], e, st);
        end

        // Abort after one collected word, then a fresh collection.
        start_pulse();
        send_word(8'hAA, 1'b0);
        start_pulse();
        check("abort restart busy", busy, 1);
        send_word(8'h05, 1'b0);
        send_word(8'h01, 1'b0);
        collect("abort", ref_model(17'h00105), 0);

        // Asynchronous reset while subtracting.
        start_pulse();
        send_word(8'h05, 1'b0);
        send_word(8'h01, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("sub rst busy", busy, 0);
        check("sub rst in_ready", in_ready, 0);
        check("sub rst out_valid", out_valid, 0);
        check("sub rst out_word", out_word, 0);
        check("sub rst out_last", out_last, 0);
        check("sub rst done", done, 0);
        check("sub rst p_addr", p_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || done) seen_valid++;
        end
        check("post rst quiet", seen_valid, 0);
        @(posedge clk); #1;
        run_vec("post rst", 8'h00, 8'h00, 1'b1, ref_model(17'h10000), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
